// File: rtl/acc_pkg.sv
// Shared definitions for the nibble accumulator
// and the window-capture stage that consumes it.
package acc_pkg;

  localparam int ACC_DATA_W = 6;
  localparam int WIN_CNT_W  = 8;
  localparam int CYC_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } acc_state_e;

endpackage

// File: rtl/acc_window_capture_sat_counter.sv
// Saturating up-counter with synchronous clear;
// nxt is the value the register takes on this edge.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] nxt
);

  logic [W-1:0] q;

  always_comb begin
    nxt = q;
    if (clr) begin
      nxt = '0;
    end else if (inc && (q != '1)) begin
      nxt = q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/acc_window_capture.sv
// Observes the accumulator for WINDOW cycles and holds
// sum, peak and overflow stats behind a valid/ready handshake.
module acc_window_capture
  import acc_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W,
  parameter int WINDOW = 8,
  parameter int OVC_W  = 4
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic [DATA_W-1:0]    i_acc_data,
  input  logic                 i_acc_ovf,
  input  logic                 i_start,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic                 o_valid,
  output logic [DATA_W-1:0]    o_sum,
  output logic [DATA_W-1:0]    o_peak,
  output logic                 o_ovf,
  output logic [OVC_W-1:0]     o_ovf_cnt,
  output logic [WIN_CNT_W-1:0] o_win_cnt
);

  localparam logic [CYC_W-1:0] LAST = CYC_W'(WINDOW - 1);

  acc_state_e state, state_nx;

  logic [CYC_W-1:0]  cyc;
  logic [DATA_W-1:0] peak, peak_nx;
  logic              sticky, sticky_nx;
  logic [OVC_W-1:0]  ovc_nx;
  logic              run, last, accept, clr;

  always_comb begin
    run      = (state == RUN);
    last     = run && (cyc == LAST);
    accept   = (state == HOLD) && i_ready;
    clr      = !run;
    state_nx = state;
    unique case (state)
      IDLE: if (i_start) state_nx = RUN;
      RUN:  if (last) state_nx = HOLD;
      HOLD: begin
        if (i_ready) begin
          state_nx = i_start ? RUN : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    peak_nx   = (i_acc_data > peak) ? i_acc_data : peak;
    sticky_nx = sticky | i_acc_ovf;
  end

  sat_counter #(
    .W(OVC_W)
  ) u_ovc (
    .clk  (clk),
    .i_rst(i_rst),
    .clr  (clr),
    .inc  (run && i_acc_ovf),
    .nxt  (ovc_nx)
  );

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Window internals only live in RUN; any other state
  // parks them at zero so HOLD->RUN starts clean.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cyc    <= '0;
      peak   <= '0;
      sticky <= 1'b0;
    end else if (clr) begin
      cyc    <= '0;
      peak   <= '0;
      sticky <= 1'b0;
    end else begin
      cyc    <= cyc + CYC_W'(1);
      peak   <= peak_nx;
      sticky <= sticky_nx;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_busy    <= 1'b0;
      o_valid   <= 1'b0;
      o_sum     <= '0;
      o_peak    <= '0;
      o_ovf     <= 1'b0;
      o_ovf_cnt <= '0;
      o_win_cnt <= '0;
    end else begin
      o_busy  <= (state_nx == RUN);
      o_valid <= (state_nx == HOLD);
      if (last) begin
        o_sum     <= i_acc_data;
        o_peak    <= peak_nx;
        o_ovf     <= sticky_nx;
        o_ovf_cnt <= ovc_nx;
      end
      if (accept) begin
        o_win_cnt <= o_win_cnt + WIN_CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/acc_window_capture.md
Name: acc_window_capture

Overview:
- Downstream consumer of the 6-bit nibble accumulator (6-bit sum plus a one-cycle carry/overflow flag).
- Observes the accumulator output over a programmable window of WINDOW clock cycles.
- Captures the final sum, a sticky overflow flag, a saturating overflow-event count and the peak sum seen.
- Presents the captured result with a valid/ready handshake, for the register/readout stage.

Parameters:
- DATA_W, 6, width of the accumulator sum input.
- WINDOW, 8, number of cycles observed per window; legal range 1..255.
- OVC_W, 4, width of the saturating overflow-event counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_acc_data  input  DATA_W  accumulator sum, sampled every RUN cycle.
- i_acc_ovf  input  1  accumulator overflow/carry flag, one-cycle pulses.
- i_start  input  1  start a window; honoured in IDLE, or in HOLD together with i_ready.
- i_ready  input  1  consumer accepts the result.
- o_busy  output  1  high in RUN.
- o_valid  output  1  result registers hold a valid window result.
- o_sum  output  DATA_W  i_acc_data sampled on the last window cycle.
- o_peak  output  DATA_W  maximum i_acc_data over the window, unsigned.
- o_ovf  output  1  sticky OR of i_acc_ovf over the window.
- o_ovf_cnt  output  OVC_W  number of window cycles with i_acc_ovf=1; saturates at all-ones.
- o_win_cnt  output  8  completed, accepted windows; wraps 255->0.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - o_busy=0, o_valid=0.
  - o_sum, o_peak, o_ovf, o_ovf_cnt, o_win_cnt all 0.
  - Internal cycle counter=0.
- FSM states: IDLE, RUN, HOLD; registered state, registered outputs.
- IDLE:
  - i_start=1 -> RUN next cycle.
  - Clear the internal peak, sticky, ovf count and cycle counter.
  - Output registers keep their last captured values.
- RUN, every cycle:
  - peak = max(peak, i_acc_data).
  - sticky |= i_acc_ovf.
  - ovf count += i_acc_ovf, saturating.
  - cycle counter += 1.
- RUN termination:
  - On the cycle where cycle counter == WINDOW-1, that cycle's inputs are included.
  - Load o_sum=i_acc_data, o_peak, o_ovf, o_ovf_cnt from the updated values.
  - Next cycle: o_valid=1, state=HOLD, o_busy=0.
- Latency: exactly WINDOW RUN cycles.
  - First RUN cycle is the cycle after i_start is sampled.
  - o_valid rises on the cycle after the last RUN cycle.
- RUN ignores i_start; there is no restart mid-window.
- HOLD:
  - o_valid=1; outputs stable until i_ready=1 is sampled.
  - i_ready=1 and i_start=0 -> IDLE, o_valid=0, o_win_cnt+=1.
  - i_ready=1 and i_start=1 -> RUN directly, o_valid=0, o_win_cnt+=1, internals cleared; there is no IDLE bubble.
- i_ready outside HOLD is ignored.
- o_win_cnt only increments on an accepted handshake, never on capture alone.
- WINDOW=1: RUN lasts one cycle; peak equals o_sum.
- Comparisons and max are unsigned over DATA_W bits. The cycle counter is 8 bits wide.
- Reset during RUN or HOLD aborts the window. The result is discarded and the reset values above apply.

Decomposition:
- Shared package acc_pkg holds:
  - The state encoding, localparam IDLE=2'd0, RUN=2'd1, HOLD=2'd2.
  - The DATA_W default constant, shared with the accumulator.
- One natural sub-module: sat_counter, a parameterised saturating up-counter with clear and increment enable, used for o_ovf_cnt.
- Everything else stays in the top module.

Test Plan:
- Reset mid-RUN: WINDOW=8, start, assert i_rst on RUN cycle 3 -> all outputs 0, state IDLE, no o_valid afterwards.
- Basic window: WINDOW=4, i_acc_data=5,20,63,10, i_acc_ovf=0 -> o_valid rises 5 cycles after i_start; o_sum=10, o_peak=63, o_ovf=0, o_ovf_cnt=0.
- Overflow capture:
  - Stimulus: ovf pulses on 2 of 4 window cycles.
  - Required: o_ovf=1, o_ovf_cnt=2.
  - Then a WINDOW=20 window with ovf held high throughout -> o_ovf_cnt=15 (saturated).
- Backpressure: hold i_ready=0 for 10 cycles in HOLD while inputs toggle -> outputs unchanged, o_valid stays 1. Then i_ready=1 -> o_valid=0 next cycle, o_win_cnt=1.
- Back-to-back: i_ready=1 with i_start=1 in HOLD -> next cycle o_busy=1 and o_valid=0; the second result reflects only the second window's data.
- Edge cases:
  - WINDOW=1: o_sum=o_peak=sampled value.
  - i_start during RUN: ignored, window length unchanged.
  - 256 accepted windows: o_win_cnt wraps to 0.
